mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
Multiply/divide unit controller for the P6 pipeline, sitting beside the ALU in the E stage. Owns the HI/LO registers and sequences multi-cycle mult/multu/div/divu.
- Models fixed operation latency with a busy counter.
- Raises a stall toward the D stage while an operation is in flight.
- Services mthi/mtlo writes and mfhi/mflo reads.

Parameters:
MULT_CYCLES, 5, cycles Busy_Out stays high for mult/multu
DIV_CYCLES, 10, cycles Busy_Out stays high for div/divu

Ports:
Clk_In  input  1  system clock, rising edge
Reset_N_In  input  1  asynchronous, active-low reset
Op_In  input  6  E-stage opcode
Func_In  input  6  E-stage funct field
SrcA_In  input  32  rs operand (forwarded)
SrcB_In  input  32  rt operand (forwarded)
Md_Inst_D_In  input  1  D-stage instruction is any MDU instruction (mult/div/mt/mf family)
Busy_Out  output  1  operation in flight
Stall_Out  output  1  freeze D stage and insert bubble into E
Hi_Out  output  32  current HI register
Lo_Out  output  32  current LO register
Result_Out  output  32  mfhi → HI, mflo → LO, otherwise 0

Behaviour:
- Decode applies only when Op_In == 000000. Func codes:
  - mult 011000, multu 011001, div 011010, divu 011011
  - mthi 010001, mtlo 010011, mfhi 010000, mflo 010010
- Start_E (internal) = decoded mult/multu/div/divu in E while state IDLE.
- Reset (Reset_N_In low, any time, including mid-operation): state IDLE, counter 0, HI = LO = 0, pending registers 0, Busy_Out = 0. The in-flight operation is discarded.
- States:
  - IDLE: on Start_E at the clock edge, latch the computed {hi,lo} into pending registers, load the counter with MULT_CYCLES or DIV_CYCLES, and go BUSY.
  - BUSY: the counter decrements each cycle. When the counter == 1 at an edge, commit pending to HI/LO, clear the counter, and go IDLE.
- Timing: Busy_Out = (state == BUSY). It is high for exactly N cycles after the start edge. HI/LO take the new value on the edge that ends the N-th busy cycle.
- Arithmetic:
  - mult: signed 32x32→64. HI = [63:32], LO = [31:0].
  - multu: same split, unsigned.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - divu: unsigned quotient/remainder.
  - Divide by zero (div or divu): the operation still goes BUSY for DIV_CYCLES, but HI/LO keep their old values at commit.
- mthi/mtlo in E while IDLE: write SrcA_In into HI/LO at the next edge. No busy period.
- mt/mult/div/mf decoded in E while BUSY: ignored (no state change). The pipeline guarantees this does not happen through Stall_Out.
- Stall_Out = Md_Inst_D_In & (Busy_Out | Start_E). This is combinational, so an MDU instruction directly behind a starting mult stalls in the same cycle.
- Result_Out is combinational from the current HI/LO registers. A read in the commit cycle returns the old value; a read one cycle later returns the new value.
- Simultaneous reset and start: reset wins.
- Counter width is $clog2(max(MULT_CYCLES, DIV_CYCLES) + 1). Both parameters must be ≥ 1.

Decomposition:
- Shared package/header holds:
  - funct constants (FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU, FUNC_MTHI, FUNC_MTLO, FUNC_MFHI, FUNC_MFLO)
  - OP_RTYPE
  - state encodings IDLE/BUSY
- One sub-module is natural: mdu_calc. It is purely combinational: Func_In, SrcA_In, SrcB_In → 64-bit {hi,lo} plus a div_by_zero flag.
- mdu_ctrl keeps the FSM, counter, pending and HI/LO registers, and the stall logic.

Test Plan:
- mult, A=0xFFFFFFFF, B=0x00000002 → Busy_Out high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE; mfhi next cycle gives 0xFFFFFFFF.
- multu, same operands → HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- div, A=0xFFFFFFF9 (-7), B=2 → Busy_Out 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- divu, A=7, B=0 after mthi 0x12345678 and mtlo 0x9ABCDEF0 → busy 10 cycles; HI/LO unchanged at 0x12345678 / 0x9ABCDEF0.
- mult started with Md_Inst_D_In=1 → Stall_Out=1 in the start cycle and all 5 busy cycles, 0 in the cycle after commit. With Md_Inst_D_In=0, Stall_Out=0 throughout.
- Reset_N_In pulsed low in the 3rd busy cycle of a div → Busy_Out, HI and LO all 0 immediately (asynchronously); no commit afterwards. A new mult after reset release completes normally.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared decode constants and FSM state encoding for the multiply/divide unit.
package mdu_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE   = 6'b000000;

   localparam logic [5:0] FUNC_MULT  = 6'b011000;
   localparam logic [5:0] FUNC_MULTU = 6'b011001;
   localparam logic [5:0] FUNC_DIV   = 6'b011010;
   localparam logic [5:0] FUNC_DIVU  = 6'b011011;
   localparam logic [5:0] FUNC_MTHI  = 6'b010001;
   localparam logic [5:0] FUNC_MTLO  = 6'b010011;
   localparam logic [5:0] FUNC_MFHI  = 6'b010000;
   localparam logic [5:0] FUNC_MFLO  = 6'b010010;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

endpackage

// File: rtl/mdu_calc.sv
// Combinational MDU arithmetic: produces {hi,lo} for mult/multu/div/divu and
// flags a zero divisor so the controller can suppress the commit.
module mdu_calc
   import mdu_ctrl_pkg::*;
(
   input  logic [5:0]  i_func,
   input  logic [31:0] i_src_a,
   input  logic [31:0] i_src_b,
   output logic [63:0] o_hilo,
   output logic        o_div_by_zero
);

   logic signed [63:0] w_a_ext_s;
   logic signed [63:0] w_b_ext_s;
   logic signed [63:0] w_prod_s;
   logic        [63:0] w_prod_u;
   logic               w_b_zero;
   logic               w_div_ovf;
   logic signed [31:0] w_a_s;
   logic signed [31:0] w_b_safe_s;
   logic signed [31:0] w_quo_s;
   logic signed [31:0] w_rem_s;
   logic        [31:0] w_b_safe_u;
   logic        [31:0] w_quo_u;
   logic        [31:0] w_rem_u;

   assign w_a_ext_s = {{32{i_src_a[31]}}, i_src_a};
   assign w_b_ext_s = {{32{i_src_b[31]}}, i_src_b};
   assign w_prod_s  = w_a_ext_s * w_b_ext_s;
   assign w_prod_u  = {32'd0, i_src_a} * {32'd0, i_src_b};

   // Dividing by 1 instead of 0 or -1 keeps the dividers defined; MIN/1 also
   // yields exactly the required MIN/-1 result (quotient MIN, remainder 0).
   assign w_b_zero   = (i_src_b == 32'd0);
   assign w_div_ovf  = (i_src_a == 32'h8000_0000) && (i_src_b == 32'hFFFF_FFFF);
   assign w_a_s      = i_src_a;
   assign w_b_safe_s = (w_b_zero || w_div_ovf) ? 32'sd1 : i_src_b;
   assign w_quo_s    = w_a_s / w_b_safe_s;
   assign w_rem_s    = w_a_s % w_b_safe_s;
   assign w_b_safe_u = w_b_zero ? 32'd1 : i_src_b;
   assign w_quo_u    = i_src_a / w_b_safe_u;
   assign w_rem_u    = i_src_a % w_b_safe_u;

   always_comb begin
      o_hilo        = '0;
      o_div_by_zero = 1'b0;
      case (i_func)
         FUNC_MULT:  o_hilo = w_prod_s;
         FUNC_MULTU: o_hilo = w_prod_u;
         FUNC_DIV: begin
            o_hilo        = {w_rem_s, w_quo_s};
            o_div_by_zero = w_b_zero;
         end
         FUNC_DIVU: begin
            o_hilo        = {w_rem_u, w_quo_u};
            o_div_by_zero = w_b_zero;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: owns HI/LO, sequences fixed-latency mult/div through a busy
// counter and stalls the D stage while an operation is in flight.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        Clk_In,
   input  logic        Reset_N_In,
   input  logic [5:0]  Op_In,
   input  logic [5:0]  Func_In,
   input  logic [31:0] SrcA_In,
   input  logic [31:0] SrcB_In,
   input  logic        Md_Inst_D_In,
   output logic        Busy_Out,
   output logic        Stall_Out,
   output logic [31:0] Hi_Out,
   output logic [31:0] Lo_Out,
   output logic [31:0] Result_Out
);
   import mdu_ctrl_pkg::*;

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e           r_state;
   state_e           w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;
   logic [31:0]      r_pend_hi;
   logic [31:0]      r_pend_lo;
   logic             r_pend_dbz;

   logic             w_rtype;
   logic             w_is_mult;
   logic             w_is_div;
   logic             w_is_mthi;
   logic             w_is_mtlo;
   logic             w_start_e;
   logic [63:0]      w_hilo;
   logic             w_div_by_zero;

   assign w_rtype   = (Op_In == OP_RTYPE);
   assign w_is_mult = w_rtype && ((Func_In == FUNC_MULT) || (Func_In == FUNC_MULTU));
   assign w_is_div  = w_rtype && ((Func_In == FUNC_DIV)  || (Func_In == FUNC_DIVU));
   assign w_is_mthi = w_rtype && (Func_In == FUNC_MTHI);
   assign w_is_mtlo = w_rtype && (Func_In == FUNC_MTLO);
   assign w_start_e = (w_is_mult || w_is_div) && (r_state == IDLE);

   mdu_calc u_calc (
      .i_func        (Func_In),
      .i_src_a       (SrcA_In),
      .i_src_b       (SrcB_In),
      .o_hilo        (w_hilo),
      .o_div_by_zero (w_div_by_zero)
   );

   always_ff @(posedge Clk_In or negedge Reset_N_In) begin
      if (!Reset_N_In) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: if (w_start_e)        w_next_state = BUSY;
         BUSY: if (r_cnt == CNT_ONE) w_next_state = IDLE;
      endcase
   end

   // Operands are captured at the start edge, so the E stage may move on freely.
   always_ff @(posedge Clk_In or negedge Reset_N_In) begin
      if (!Reset_N_In) begin
         r_cnt      <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_pend_hi  <= '0;
         r_pend_lo  <= '0;
         r_pend_dbz <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start_e) begin
                  r_pend_hi  <= w_hilo[63:32];
                  r_pend_lo  <= w_hilo[31:0];
                  r_pend_dbz <= w_div_by_zero;
                  r_cnt      <= w_is_mult ? CNT_MULT : CNT_DIV;
               end else if (w_is_mthi) begin
                  r_hi <= SrcA_In;
               end else if (w_is_mtlo) begin
                  r_lo <= SrcA_In;
               end
            end
            BUSY: begin
               if (r_cnt == CNT_ONE) begin
                  r_cnt <= '0;
                  if (!r_pend_dbz) begin
                     r_hi <= r_pend_hi;
                     r_lo <= r_pend_lo;
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
         endcase
      end
   end

   assign Busy_Out  = (r_state == BUSY);
   assign Stall_Out = Md_Inst_D_In && (Busy_Out || w_start_e);
   assign Hi_Out    = r_hi;
   assign Lo_Out    = r_lo;

   always_comb begin
      Result_Out = '0;
      if (w_rtype && (Func_In == FUNC_MFHI)) Result_Out = r_hi;
      if (w_rtype && (Func_In == FUNC_MFLO)) Result_Out = r_lo;
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed table-driven bench for mdu_ctrl plus hand sequences for reset
// mid-operation and commit-cycle read/ignore behaviour.
module tb_mdu_ctrl;

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_NOP   = 6'b100000;

   logic        clk;
   logic        rst_n;
   logic [5:0]  op;
   logic [5:0]  func;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        md_d;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] result;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic [5:0]  func;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
      logic        md_d;
   } vec_t;

   vec_t tbl [12];

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .Clk_In       (clk),
      .Reset_N_In   (rst_n),
      .Op_In        (op),
      .Func_In      (func),
      .SrcA_In      (src_a),
      .SrcB_In      (src_b),
      .Md_Inst_D_In (md_d),
      .Busy_Out     (busy),
      .Stall_Out    (stall),
      .Hi_Out       (hi),
      .Lo_Out       (lo),
      .Result_Out   (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_op(input vec_t v, input string tag);
      int   cnt;
      logic stall_bad;
      @(negedge clk);
      op    = 6'd0;
      func  = v.func;
      src_a = v.a;
      src_b = v.b;
      md_d  = v.md_d;
      #1;
      stall_bad = (stall !== (v.md_d && (v.cycles > 0)));
      @(posedge clk);
      #1 func = F_NOP;
      @(negedge clk);
      cnt = 0;
      while (busy === 1'b1 && cnt < 40) begin
         cnt++;
         if (stall !== md_d) stall_bad = 1'b1;
         @(negedge clk);
      end
      chk({tag, " busy_cycles"}, 32'(cnt), 32'(v.cycles));
      chk({tag, " stall_busy"}, {31'd0, stall_bad}, 32'd0);
      chk({tag, " stall_after"}, {31'd0, stall}, 32'd0);
      chk({tag, " hi"}, hi, v.hi);
      chk({tag, " lo"}, lo, v.lo);
      func = F_MFHI;
      #1 chk({tag, " mfhi"}, result, v.hi);
      func = F_MFLO;
      #1 chk({tag, " mflo"}, result, v.lo);
      func = F_NOP;
      md_d = 1'b0;
   endtask

   initial begin
      logic bad;
      tbl[0]  = '{F_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5,  1'b1};
      tbl[1]  = '{F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 5,  1'b0};
      tbl[2]  = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b1};
      tbl[3]  = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10, 1'b0};
      tbl[4]  = '{F_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 10, 1'b0};
      tbl[5]  = '{F_MULT,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5,  1'b0};
      tbl[6]  = '{F_MTHI,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 0,  1'b1};
      tbl[7]  = '{F_MTLO,  32'h9ABC_DEF0, 32'h0000_0000, 32'h1234_5678, 32'h9ABC_DEF0, 0,  1'b0};
      tbl[8]  = '{F_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h1234_5678, 32'h9ABC_DEF0, 10, 1'b1};
      tbl[9]  = '{F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10, 1'b0};
      tbl[10] = '{F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5,  1'b0};
      tbl[11] = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5,  1'b1};

      rst_n = 1'b0;
      op    = 6'd0;
      func  = F_NOP;
      src_a = 32'd0;
      src_b = 32'd0;
      md_d  = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset stall", {31'd0, stall}, 32'd0);
      chk("reset hi", hi, 32'd0);
      chk("reset lo", lo, 32'd0);
      chk("reset result", result, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) run_op(tbl[i], $sformatf("vec%0d", i));

      // Asynchronous reset in the third busy cycle of a div
      @(negedge clk);
      func  = F_DIV;
      src_a = 32'd100;
      src_b = 32'd7;
      @(posedge clk);
      #1 func = F_NOP;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid busy", {31'd0, busy}, 32'd0);
      chk("rst_mid hi", hi, 32'd0);
      chk("rst_mid lo", lo, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad = 1'b1;
      end
      chk("rst_mid no_commit", {31'd0, bad}, 32'd0);
      run_op(tbl[0], "post_rst");

      // Commit-cycle read returns old LO; MDU ops issued while busy are ignored
      @(negedge clk);
      func  = F_MULT;
      src_a = 32'd3;
      src_b = 32'd5;
      @(negedge clk);
      func  = F_MTHI;
      src_a = 32'hDEAD_BEEF;
      @(negedge clk);
      func  = F_MULT;
      src_a = 32'd7;
      src_b = 32'd7;
      @(negedge clk);
      func  = F_NOP;
      @(negedge clk);
      @(negedge clk);
      func  = F_MFLO;
      #1;
      chk("commit_cyc busy", {31'd0, busy}, 32'd1);
      chk("commit_cyc old_lo", result, 32'hFFFF_FFFE);
      chk("commit_cyc old_hi", hi, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("after_commit busy", {31'd0, busy}, 32'd0);
      chk("after_commit hi", hi, 32'd0);
      chk("after_commit lo", lo, 32'd15);
      chk("after_commit mflo", result, 32'd15);
      func = F_NOP;
      @(negedge clk);
      chk("no_restart busy", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
